// File: rtl/pc_flow_unit.sv
// Program counter and branch/jump flow control: registers the next PC one edge after decode, driven by the ALU ZERO flag.
// BUSYWAIT holds the PC and drops FETCH_VALID. Out of reset there is one fetch hold cycle before the PC advances.
module pc_flow_unit #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned OFFSET_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    BUSYWAIT,
    input  logic                    JUMP,
    input  logic                    BRANCH,
    input  logic                    BRANCH_NE,
    input  logic                    ZERO,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    output logic [PC_WIDTH-1:0]     PC,
    output logic [PC_WIDTH-1:0]     PC_PLUS4,
    output logic                    FETCH_VALID,
    output logic [CNT_WIDTH-1:0]    TAKEN_COUNT
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  fetch_vld_q, fetch_vld_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [PC_WIDTH-1:0]   offset_ext;
    logic [PC_WIDTH-1:0]   target;
    logic                  taken;
    logic [PC_WIDTH-1:0]   next_pc;

    assign PC_PLUS4   = pc_q + PC_WIDTH'(4);
    assign offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){OFFSET[OFFSET_WIDTH-1]}}, OFFSET};
    assign target     = PC_PLUS4 + (offset_ext << 2);

    // Both branch flavours asserted together is an illegal encoding and falls through to PC+4.
    assign taken   = JUMP
                   | (BRANCH & ~BRANCH_NE & ZERO)
                   | (BRANCH_NE & ~BRANCH & ~ZERO);
    assign next_pc = taken ? target : PC_PLUS4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_vld_d = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            S_HOLD: begin
                fetch_vld_d = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN, S_STALL: begin
                if (BUSYWAIT) begin
                    state_d = S_STALL;
                end else begin
                    pc_d        = next_pc;
                    fetch_vld_d = 1'b1;
                    state_d     = S_RUN;
                    if (taken && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_HOLD;
            pc_q        <= RESET_PC;
            fetch_vld_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_vld_q <= fetch_vld_d;
            cnt_q       <= cnt_d;
        end
    end

    assign PC          = pc_q;
    assign FETCH_VALID = fetch_vld_q;
    assign TAKEN_COUNT = cnt_q;

endmodule

// File: tb/tb_pc_flow_unit.sv
// Directed bench for pc_flow_unit: vector table for sequencing/branch cases, hand sequences for reset, saturation and async reset.
module tb_pc_flow_unit;

    logic        CLK;
    logic        RESET;
    logic        BUSYWAIT;
    logic        JUMP;
    logic        BRANCH;
    logic        BRANCH_NE;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        FETCH_VALID;
    logic [7:0]  TAKEN_COUNT;

    int n_checks = 0;
    int n_errors = 0;

    pc_flow_unit #(
        .PC_WIDTH(32), .OFFSET_WIDTH(8), .RESET_PC(32'h0), .CNT_WIDTH(8)
    ) dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .JUMP(JUMP),
        .BRANCH(BRANCH), .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .OFFSET(OFFSET),
        .PC(PC), .PC_PLUS4(PC_PLUS4), .FETCH_VALID(FETCH_VALID),
        .TAKEN_COUNT(TAKEN_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        bw, jmp, br, bne, z;
        logic [7:0]  off;
        logic [31:0] pc;
        logic        fv;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic bw, jmp, br, bne, z, input logic [7:0] off,
                                input logic [31:0] pc, input logic fv, input logic [7:0] cnt);
        vec_t v;
        v.bw = bw; v.jmp = jmp; v.br = br; v.bne = bne; v.z = z; v.off = off;
        v.pc = pc; v.fv = fv; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic bw, jmp, br, bne, z, input logic [7:0] off);
        BUSYWAIT = bw; JUMP = jmp; BRANCH = br; BRANCH_NE = bne; ZERO = z; OFFSET = off;
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic fv, input logic [7:0] cnt);
        chk({tag, " PC"}, PC, pc);
        chk({tag, " PC_PLUS4"}, PC_PLUS4, pc + 32'd4);
        chk({tag, " FETCH_VALID"}, {31'd0, FETCH_VALID}, {31'd0, fv});
        chk({tag, " TAKEN_COUNT"}, {24'd0, TAKEN_COUNT}, {24'd0, cnt});
    endtask

    initial begin
        //          bw jmp br bne z  off     pc            fv cnt
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 32'd4,        1, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 32'd8,        1, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 32'd12,       1, 8'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'hFE, 32'd8,        1, 8'd1));  // 12+4-8
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h03, 32'd24,       1, 8'd2));  // beq taken
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h03, 32'd28,       1, 8'd2));  // beq not taken
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h02, 32'd40,       1, 8'd3));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'hFC, 32'd28,       1, 8'd4));  // bne taken, negative
        tbl.push_back(mk(0, 1, 0, 0, 1, 8'hFF, 32'd28,       1, 8'd5));  // jump -1
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h10, 32'd32,       1, 8'd5));  // illegal encoding
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h10, 32'd36,       1, 8'd5));  // illegal encoding
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'h10, 32'd40,       1, 8'd5));  // bne not taken
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 32'd44,       1, 8'd6));  // zero offset still taken
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h80, 32'hFFFFFE30, 1, 8'd7));  // 44+4-512
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h72, 32'hFFFFFFFC, 1, 8'd8));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h01, 32'd4,        1, 8'd9));  // wraps
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h02, 32'd16,       1, 8'd10));
        tbl.push_back(mk(1, 0, 1, 0, 1, 8'h02, 32'd16,       0, 8'd10)); // stall x3
        tbl.push_back(mk(1, 0, 1, 0, 1, 8'h02, 32'd16,       0, 8'd10));
        tbl.push_back(mk(1, 0, 1, 0, 1, 8'h02, 32'd16,       0, 8'd10));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h02, 32'd28,       1, 8'd11)); // release
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h20, 32'd28,       0, 8'd11));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h20, 32'd32,       1, 8'd11)); // release edge inputs rule

        drive(0, 0, 0, 0, 0, 8'h00);
        RESET = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk_state("reset", 32'd0, 1'b0, 8'd0);
        step();
        chk_state("reset held", 32'd0, 1'b0, 8'd0);
        @(negedge CLK);
        RESET = 1'b0;
        drive(0, 1, 0, 0, 0, 8'h05);
        step();
        chk_state("hold", 32'd0, 1'b1, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].bw, tbl[i].jmp, tbl[i].br, tbl[i].bne, tbl[i].z, tbl[i].off);
            step();
            chk_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fv, tbl[i].cnt);
        end

        // Counter saturation: 11 taken so far, 300 more zero-offset jumps.
        drive(0, 1, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 243) chk("sat-1 count", {24'd0, TAKEN_COUNT}, 32'd254);
            if (k == 244) chk("sat count", {24'd0, TAKEN_COUNT}, 32'd255);
        end
        chk_state("sat end", 32'd32 + 32'd1200, 1'b1, 8'd255);

        // Async reset landing between edges while stalled.
        drive(1, 0, 0, 0, 0, 8'h00);
        step();
        chk_state("pre-reset stall", 32'd1232, 1'b0, 8'd255);
        #2 RESET = 1'b1;
        #1;
        chk_state("async reset", 32'd0, 1'b0, 8'd0);
        @(negedge CLK);
        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 8'h00);
        step();
        chk_state("post-reset hold", 32'd0, 1'b1, 8'd0);
        step();
        chk_state("post-reset run", 32'd4, 1'b1, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
